// File: rtl/blink_rate_decoder.sv
// Blink-rate decoder: measures the half-period of an async blink line and recovers its 2-bit rate code.
// Latency: registered outputs update 3 clk after the pin toggles (2-flop sync + edge-detect flop).
// Backpressure: none; free-running receiver, code is held until a new code is confirmed or lock is lost.
//
// Ports:
//   CLOCK_50    in   system clock
//   rst         in   synchronous reset, active-high
//   blink_in    in   asynchronous blink line from the pin
//   blink_level out  synchronized blink level (second sync flop)
//   code        out  recovered rate code (00 fast, 10 mid, 01 slow), held while valid
//   code_valid  out  code confirmed by two consecutive matching half-periods
//   code_change out  one-cycle pulse when a different code (or a first code) is confirmed
//   stall       out  no transition seen for TIMEOUT cycles
module blink_rate_decoder #(
  parameter int unsigned HALF_FAST = 5000001,
  parameter int unsigned HALF_MID  = 50000001,
  parameter int unsigned HALF_SLOW = 750000001,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned CW        = 31
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       blink_in,
  output logic       blink_level,
  output logic [1:0] code,
  output logic       code_valid,
  output logic       code_change,
  output logic       stall
);

  localparam logic [1:0] C_FAST = 2'b00;
  localparam logic [1:0] C_SLOW = 2'b01;
  localparam logic [1:0] C_MID  = 2'b10;

  // Acceptance windows: HALF_x +/- (HALF_x >> TOL_SHIFT), inclusive.
  localparam logic [CW-1:0] FAST_LO = CW'(HALF_FAST - (HALF_FAST >> TOL_SHIFT));
  localparam logic [CW-1:0] FAST_HI = CW'(HALF_FAST + (HALF_FAST >> TOL_SHIFT));
  localparam logic [CW-1:0] MID_LO  = CW'(HALF_MID  - (HALF_MID  >> TOL_SHIFT));
  localparam logic [CW-1:0] MID_HI  = CW'(HALF_MID  + (HALF_MID  >> TOL_SHIFT));
  localparam logic [CW-1:0] SLOW_LO = CW'(HALF_SLOW - (HALF_SLOW >> TOL_SHIFT));
  localparam logic [CW-1:0] SLOW_HI = CW'(HALF_SLOW + (HALF_SLOW >> TOL_SHIFT));
  // One past the widest accepted half-period: anything longer can never classify.
  localparam logic [CW-1:0] TIMEOUT = CW'(HALF_SLOW + (HALF_SLOW >> TOL_SHIFT) + 1);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_CAND, S_LOCK} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cand_q, cand_d;
  logic [1:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          chg_q, chg_d;
  logic          stall_q, stall_d;

  logic          edge_det;
  logic          timeout;
  logic          cls_vld;
  logic [1:0]    cls_code;

  assign edge_det = s2_q ^ s3_q;
  // Edge wins over a coincident timeout; an idle line cannot time out again.
  assign timeout  = !edge_det && (cnt_q == TIMEOUT) && (state_q != S_IDLE);

  // At an edge cnt_q holds the cycles since the previous edge.
  always_comb begin
    cls_vld  = 1'b1;
    cls_code = C_FAST;
    if ((cnt_q >= FAST_LO) && (cnt_q <= FAST_HI)) begin
      cls_code = C_FAST;
    end else if ((cnt_q >= MID_LO) && (cnt_q <= MID_HI)) begin
      cls_code = C_MID;
    end else if ((cnt_q >= SLOW_LO) && (cnt_q <= SLOW_HI)) begin
      cls_code = C_SLOW;
    end else begin
      cls_vld = 1'b0;
    end
  end

  always_comb begin
    if (edge_det) begin
      cnt_d = CW'(1);
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (edge_det) state_d = S_FIRST;
      end
      S_FIRST: begin
        if (edge_det && cls_vld) state_d = S_CAND;
        else if (timeout)        state_d = S_IDLE;
      end
      S_CAND: begin
        if (edge_det) begin
          if (!cls_vld)                state_d = S_FIRST;
          else if (cls_code == cand_q) state_d = S_LOCK;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (edge_det) begin
          if (!cls_vld)                 state_d = S_FIRST;
          else if (cls_code != code_q)  state_d = S_CAND;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = valid_q;
    stall_d = stall_q;
    chg_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (edge_det) stall_d = 1'b0;
      end
      S_FIRST: begin
        if (edge_det && cls_vld) cand_d = cls_code;
      end
      S_CAND: begin
        if (edge_det && cls_vld) begin
          if (cls_code == cand_q) begin
            code_d  = cand_q;
            valid_d = 1'b1;
            chg_d   = !valid_q || (cand_q != code_q);
          end else begin
            cand_d = cls_code;
          end
        end
      end
      S_LOCK: begin
        if (edge_det) begin
          if (!cls_vld)                valid_d = 1'b0;
          else if (cls_code != code_q) cand_d  = cls_code;
        end
      end
      default: ;
    endcase
    // code is kept on timeout so the display still shows the last rate.
    if (timeout) begin
      valid_d = 1'b0;
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      cand_q  <= C_FAST;
      code_q  <= C_MID;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      s1_q    <= blink_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      stall_q <= stall_d;
    end
  end

  assign blink_level = s2_q;
  assign code        = code_q;
  assign code_valid  = valid_q;
  assign code_change = chg_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Testbench for blink_rate_decoder with shortened half-periods (11/101/1501, TIMEOUT 1877).
// Output events (any change of code/code_valid/stall, or a code_change pulse) are
// matched in order against a queue of expected events pushed as stimulus is driven.
module tb_blink_rate_decoder;

  logic       CLOCK_50;
  logic       rst;
  logic       blink_in;
  logic       blink_level;
  logic [1:0] code;
  logic       code_valid;
  logic       code_change;
  logic       stall;

  blink_rate_decoder #(
    .HALF_FAST(11),
    .HALF_MID (101),
    .HALF_SLOW(1501),
    .TOL_SHIFT(2)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .blink_in   (blink_in),
    .blink_level(blink_level),
    .code       (code),
    .code_valid (code_valid),
    .code_change(code_change),
    .stall      (stall)
  );

  localparam int TIMEOUT = 1877;

  typedef struct packed {
    int         cyc;
    logic [1:0] code;
    logic       vld;
    logic       stl;
    logic       chg;
  } ev_t;

  ev_t  sbq[$];
  int   cyc = 0;
  int   t_last = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  logic [3:0] prev;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] cd, input logic v, input logic s, input logic ch);
    ev_t e;
    e.cyc  = c;
    e.code = cd;
    e.vld  = v;
    e.stl  = s;
    e.chg  = ch;
    sbq.push_back(e);
  endtask

  // Toggle the line n cycles after the previous toggle (toggles land 1 ns after a posedge).
  task automatic tog(input int n);
    do begin
      @(posedge CLOCK_50);
      #1;
    end while (cyc < t_last + n);
    blink_in = ~blink_in;
    t_last   = cyc;
  endtask

  // Advance to the falling edge of cycle c.
  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge CLOCK_50);
  endtask

  always @(negedge CLOCK_50) begin
    logic [3:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {code, code_valid, stall};
      if ((cur !== prev) || (code_change !== 1'b0)) begin
        chk("sb_expected", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("ev_cyc",   cyc,         e.cyc);
          chk("ev_code",  code,        e.code);
          chk("ev_valid", code_valid,  e.vld);
          chk("ev_stall", stall,       e.stl);
          chk("ev_chg",   code_change, e.chg);
        end
      end
      prev = cur;
    end
  end

  initial begin
    blink_in = 1'b0;
    rst      = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_code",  code,        2'b10);
    chk("rst_valid", code_valid,  1'b0);
    chk("rst_chg",   code_change, 1'b0);
    chk("rst_stall", stall,       1'b0);
    chk("rst_level", blink_level, 1'b0);
    @(posedge CLOCK_50);
    #1;
    rst    = 1'b0;
    t_last = cyc;
    prev   = {2'b10, 1'b0, 1'b0};
    mon_en = 1'b1;

    // 1: fast lock after the third edge, one pulse
    tog(5);
    tog(11);
    tog(11);
    push(t_last + 3, 2'b00, 1'b1, 1'b0, 1'b1);
    at_cyc(t_last + 4);
    chk("t1_code",  code,        2'b00);
    chk("t1_chg_1cyc", code_change, 1'b0);
    chk("t1_level", blink_level, 1'b1);
    tog(11);
    at_cyc(t_last + 4);
    chk("t1_level2", blink_level, 1'b0);

    // 2: switch to mid; old code held after the first gap
    tog(101);
    at_cyc(t_last + 4);
    chk("t2_hold_code",  code,       2'b00);
    chk("t2_hold_valid", code_valid, 1'b1);
    tog(101);
    push(t_last + 3, 2'b10, 1'b1, 1'b0, 1'b1);

    // 3: slow lock, then 1100 (below slow window 1126..1876) drops the lock
    tog(1501);
    tog(1501);
    push(t_last + 3, 2'b01, 1'b1, 1'b0, 1'b1);
    tog(1100);
    push(t_last + 3, 2'b01, 1'b0, 1'b0, 1'b0);

    // 4: lock at mid, then hold the line until timeout
    tog(101);
    tog(101);
    push(t_last + 3, 2'b10, 1'b1, 1'b0, 1'b1);
    push(t_last + 3 + TIMEOUT, 2'b10, 1'b0, 1'b1, 1'b0);
    at_cyc(t_last + 3 + TIMEOUT - 1);
    chk("t4_stall_early", stall, 1'b0);
    at_cyc(t_last + 3 + TIMEOUT);
    chk("t4_stall",       stall,      1'b1);
    chk("t4_valid",       code_valid, 1'b0);
    chk("t4_code_kept",   code,       2'b10);
    tog(1900);
    push(t_last + 3, 2'b10, 1'b0, 1'b0, 1'b0);

    // 5: window edges 9/13 accepted, 8/14 rejected
    tog(9);
    tog(13);
    push(t_last + 3, 2'b00, 1'b1, 1'b0, 1'b1);
    tog(8);
    push(t_last + 3, 2'b00, 1'b0, 1'b0, 1'b0);
    tog(14);
    tog(8);
    tog(14);
    at_cyc(t_last + 4);
    chk("t5_no_lock", code_valid, 1'b0);
    // Edge coinciding with the timeout count: edge wins, no stall.
    tog(TIMEOUT);
    at_cyc(t_last + 4);
    chk("t5_edge_wins", stall, 1'b0);

    // 6: reset while in S_CAND, then relock from scratch
    tog(11);
    tog(11);
    push(t_last + 3, 2'b00, 1'b1, 1'b0, 1'b1);
    tog(101);
    at_cyc(t_last + 20);
    @(posedge CLOCK_50);
    #1;
    rst = 1'b1;
    push(cyc + 1, 2'b10, 1'b0, 1'b0, 1'b0);
    @(posedge CLOCK_50);
    #1;
    rst = 1'b0;
    chk("t6_rst_code",  code,        2'b10);
    chk("t6_rst_valid", code_valid,  1'b0);
    chk("t6_rst_chg",   code_change, 1'b0);
    chk("t6_rst_stall", stall,       1'b0);
    t_last = cyc;
    tog(30);
    tog(11);
    at_cyc(t_last + 4);
    chk("t6_no_lock_2edges", code_valid, 1'b0);
    tog(11);
    push(t_last + 3, 2'b00, 1'b1, 1'b0, 1'b1);

    at_cyc(t_last + 20);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
